ahb_dma_ch_arb: RTL

Parametrised channel arbiter for the AHB DMA engine.
- Collects per-channel transfer requests, each tagged with a programmable priority.
- Grants the bus-master interface to exactly one channel at a time.
- Highest priority wins; ties within that level are broken round-robin, starting after the last granted channel.
- Sits between the channel register file and the AHB master FSM. The grant is registered and held until the master FSM reports the end of the channel's burst.

---
 rtl/ahb_dma_arb_pkg.sv | 23 ++
 rtl/ahb_dma_pri_lvl_dec.sv | 16 +
 rtl/ahb_dma_ch_arb.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/ahb_dma_arb_pkg.sv
// Shared types and helpers for the AHB DMA channel arbiter.
package ahb_dma_arb_pkg;

    localparam int unsigned MAX_CH    = 32;
    localparam int unsigned DEF_PRI_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEL  = 2'd1,
        GNT  = 2'd2
    } arb_state_t;

    // Binary index of a one-hot vector; an all-zero input maps to 0.
    function automatic logic [4:0] onehot2idx(input logic [MAX_CH-1:0] oh);
        logic [4:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_CH; i++) begin
            if (oh[i]) idx = idx | 5'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/ahb_dma_pri_lvl_dec.sv
// Per-channel priority decoder: one-hot level vector, zero when not requesting.
module ahb_dma_pri_lvl_dec #(
    parameter int unsigned PRI_W = 3
) (
    input  logic                  valid,
    input  logic [PRI_W-1:0]      pri,
    output logic [2**PRI_W-1:0]   lvl_oh
);

    // Decode the priority into its level bit, gated by the request.
    always_comb begin
        lvl_oh = '0;
        if (valid) lvl_oh[pri] = 1'b1;
    end

endmodule

// File: rtl/ahb_dma_ch_arb.sv
// DMA channel arbiter: highest priority wins, round-robin within a level,
// grant registered and held until the burst ends or the channel drops out.
module ahb_dma_ch_arb
    import ahb_dma_arb_pkg::*;
#(
    parameter int unsigned NUM_CH = 8,
    parameter int unsigned PRI_W  = DEF_PRI_W,
    parameter int unsigned IDX_W  = $clog2(NUM_CH)
) (
    input  logic                    HCLK,
    input  logic                    HRESETn,
    input  logic                    arb_en,
    input  logic [NUM_CH-1:0]       ch_req,
    input  logic [NUM_CH*PRI_W-1:0] ch_pri,
    input  logic                    xfer_done,
    output logic                    gnt_vld,
    output logic [NUM_CH-1:0]       gnt_oh,
    output logic [IDX_W-1:0]        gnt_idx,
    output logic [PRI_W-1:0]        gnt_pri,
    output logic                    arb_busy
);

    localparam int unsigned NUM_LVL = 2**PRI_W;

    arb_state_t          state_q, state_d;
    logic [PRI_W-1:0]    lvl_q, lvl_d;
    logic [IDX_W-1:0]    last_idx_q, last_idx_d;
    logic                gnt_vld_q, gnt_vld_d;
    logic [NUM_CH-1:0]   gnt_oh_q, gnt_oh_d;
    logic [IDX_W-1:0]    gnt_idx_q, gnt_idx_d;
    logic [PRI_W-1:0]    gnt_pri_q, gnt_pri_d;

    logic [NUM_LVL-1:0]  lvl_oh [NUM_CH];
    logic [NUM_LVL-1:0]  lvl_any;
    logic [PRI_W-1:0]    max_lvl;
    logic [NUM_CH-1:0]   cand;
    logic [IDX_W-1:0]    rr_start;
    logic [NUM_CH-1:0]   rot;
    logic [NUM_CH-1:0]   win_oh;
    logic [IDX_W-1:0]    win_idx;
    logic                release_gnt;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_dec
        ahb_dma_pri_lvl_dec #(
            .PRI_W (PRI_W)
        ) u_dec (
            .valid  (ch_req[g]),
            .pri    (ch_pri[g*PRI_W +: PRI_W]),
            .lvl_oh (lvl_oh[g])
        );
    end

    // OR the per-channel level vectors and take the highest occupied level.
    always_comb begin
        lvl_any = '0;
        for (int i = 0; i < NUM_CH; i++) lvl_any = lvl_any | lvl_oh[i];
        max_lvl = '0;
        for (int i = 0; i < NUM_LVL; i++) begin
            if (lvl_any[i]) max_lvl = PRI_W'(i);
        end
    end

    // Candidates: still requesting at exactly the captured level.
    always_comb begin
        cand = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand[i] = ch_req[i] && (ch_pri[i*PRI_W +: PRI_W] == lvl_q);
        end
    end

    // Round-robin: rotate a doubled candidate vector so the search starts just
    // after the last winner, find the first set bit, then map back mod NUM_CH.
    always_comb begin
        int unsigned pos;
        logic        found;
        rr_start = (last_idx_q == IDX_W'(NUM_CH - 1)) ? '0 : last_idx_q + 1'b1;
        rot      = NUM_CH'({cand, cand} >> rr_start);
        win_oh   = '0;
        found    = 1'b0;
        pos      = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                pos   = int'(rr_start) + k;
                if (pos >= NUM_CH) pos = pos - NUM_CH;
                win_oh[pos] = 1'b1;
            end
        end
        win_idx = IDX_W'(onehot2idx(MAX_CH'(win_oh)));
    end

    assign release_gnt = xfer_done || !ch_req[gnt_idx_q];

    // FSM next-state and grant register update.
    always_comb begin
        state_d    = state_q;
        lvl_d      = lvl_q;
        last_idx_d = last_idx_q;
        gnt_vld_d  = gnt_vld_q;
        gnt_oh_d   = gnt_oh_q;
        gnt_idx_d  = gnt_idx_q;
        gnt_pri_d  = gnt_pri_q;
        unique case (state_q)
            IDLE: begin
                if (arb_en && |ch_req) begin
                    lvl_d   = max_lvl;
                    state_d = SEL;
                end
            end
            SEL: begin
                if (cand == '0) begin
                    state_d = IDLE;
                end else begin
                    gnt_oh_d  = win_oh;
                    gnt_idx_d = win_idx;
                    gnt_pri_d = lvl_q;
                    gnt_vld_d = 1'b1;
                    state_d   = GNT;
                end
            end
            GNT: begin
                if (release_gnt) begin
                    last_idx_d = gnt_idx_q;
                    gnt_vld_d  = 1'b0;
                    gnt_oh_d   = '0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; the reset search start is channel 0.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q    <= IDLE;
            lvl_q      <= '0;
            last_idx_q <= IDX_W'(NUM_CH - 1);
            gnt_vld_q  <= 1'b0;
            gnt_oh_q   <= '0;
            gnt_idx_q  <= '0;
            gnt_pri_q  <= '0;
        end else begin
            state_q    <= state_d;
            lvl_q      <= lvl_d;
            last_idx_q <= last_idx_d;
            gnt_vld_q  <= gnt_vld_d;
            gnt_oh_q   <= gnt_oh_d;
            gnt_idx_q  <= gnt_idx_d;
            gnt_pri_q  <= gnt_pri_d;
        end
    end

    assign gnt_vld  = gnt_vld_q;
    assign gnt_oh   = gnt_oh_q;
    assign gnt_idx  = gnt_idx_q;
    assign gnt_pri  = gnt_pri_q;
    assign arb_busy = (state_q != IDLE);

    a_oh_onehot0: assert property (@(posedge HCLK) disable iff (!HRESETn)
        $onehot0(gnt_oh_q));
    a_oh_idx_vld: assert property (@(posedge HCLK) disable iff (!HRESETn)
        gnt_oh_q[gnt_idx_q] == gnt_vld_q);
    a_vld_in_gnt: assert property (@(posedge HCLK) disable iff (!HRESETn)
        gnt_vld_q |-> state_q == GNT);

endmodule
